// File: rtl/rv32i_pkg.sv
// Shared RV32I pipeline types: ALU control encoding, operand-source selects
// and the register-address width, plus the forwarding-hit rule.
package rv32i_pkg;

   localparam int RA_W = 5;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SUB  = 4'b0001,
      ALU_AND  = 4'b0010,
      ALU_OR   = 4'b0011,
      ALU_SLL  = 4'b0100,
      ALU_SLT  = 4'b0101,
      ALU_SLTU = 4'b0110,
      ALU_XOR  = 4'b0111,
      ALU_SRA  = 4'b1000,
      ALU_SRL  = 4'b1001,
      ALU_BGE  = 4'b1010,
      ALU_BGEU = 4'b1011,
      ALU_BNE  = 4'b1100
   } alu_ctrl_t;

   // The reserved a-select encoding behaves exactly like the zero select.
   typedef enum logic [1:0] {
      SRC_A_RS1  = 2'b00,
      SRC_A_PC   = 2'b01,
      SRC_A_ZERO = 2'b10,
      SRC_A_RSVD = 2'b11
   } src_a_t;

   typedef enum logic {
      SRC_B_RS2 = 1'b0,
      SRC_B_IMM = 1'b1
   } src_b_t;

   // x0 is hard-wired to zero, so a producer targeting it never forwards.
   function automatic logic fwd_hit(input logic             wr_en,
                                    input logic [RA_W-1:0] prod_rd,
                                    input logic [RA_W-1:0] cons_rs);
      return wr_en && (prod_rd == cons_rs) && (cons_rs != '0);
   endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Per-operand forwarding select: MEM result beats WB result beats the
// value held in the ID/EX register.
module fwd_mux
   import rv32i_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int IDX_W = rv32i_pkg::RA_W
) (
   input  logic [IDX_W-1:0] rs,
   input  logic [WIDTH-1:0] reg_data,
   input  logic             mem_reg_write,
   input  logic [IDX_W-1:0] mem_rd,
   input  logic [WIDTH-1:0] mem_result,
   input  logic             wb_reg_write,
   input  logic [IDX_W-1:0] wb_rd,
   input  logic [WIDTH-1:0] wb_result,
   output logic [WIDTH-1:0] data
);

   logic mem_hit;
   logic wb_hit;

   always_comb begin
      mem_hit = wr_hit(mem_reg_write, mem_rd, rs);
      wb_hit  = wr_hit(wb_reg_write, wb_rd, rs);
   end

   always_comb begin
      data = reg_data;
      if (mem_hit) begin
         data = mem_result;
      end else if (wb_hit) begin
         data = wb_result;
      end
   end

   function automatic logic wr_hit(input logic             wr_en,
                                   input logic [IDX_W-1:0] prod_rd,
                                   input logic [IDX_W-1:0] cons_rs);
      return wr_en && (prod_rd == cons_rs) && (cons_rs != '0);
   endfunction

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded fields, forwards from MEM/WB,
// and drives the ALU operands plus the fields that ride along to EX.
module id_ex_stage
   import rv32i_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int RA_W  = rv32i_pkg::RA_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       id_alu_control,
   input  logic [WIDTH-1:0] id_rs1_data,
   input  logic [WIDTH-1:0] id_rs2_data,
   input  logic [WIDTH-1:0] id_imm,
   input  logic [WIDTH-1:0] id_pc,
   input  logic [RA_W-1:0]  id_rs1,
   input  logic [RA_W-1:0]  id_rs2,
   input  logic [RA_W-1:0]  id_rd,
   input  logic [1:0]       id_src_a,
   input  logic             id_src_b,
   input  logic             id_reg_write,
   input  logic             id_is_branch,
   input  logic             mem_reg_write,
   input  logic [RA_W-1:0]  mem_rd,
   input  logic [WIDTH-1:0] mem_result,
   input  logic             wb_reg_write,
   input  logic [RA_W-1:0]  wb_rd,
   input  logic [WIDTH-1:0] wb_result,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [3:0]       ex_alu_control,
   output logic [WIDTH-1:0] ex_a,
   output logic [WIDTH-1:0] ex_b,
   output logic [WIDTH-1:0] ex_store_data,
   output logic [WIDTH-1:0] ex_pc,
   output logic [WIDTH-1:0] ex_imm,
   output logic [RA_W-1:0]  ex_rd,
   output logic             ex_reg_write,
   output logic             ex_is_branch
);

   logic             valid_q;
   alu_ctrl_t        alu_ctrl_q;
   logic [WIDTH-1:0] rs1_data_q;
   logic [WIDTH-1:0] rs2_data_q;
   logic [WIDTH-1:0] imm_q;
   logic [WIDTH-1:0] pc_q;
   logic [RA_W-1:0]  rs1_q;
   logic [RA_W-1:0]  rs2_q;
   logic [RA_W-1:0]  rd_q;
   src_a_t           src_a_q;
   src_b_t           src_b_q;
   logic             reg_write_q;
   logic             is_branch_q;

   logic [WIDTH-1:0] fwd_rs1;
   logic [WIDTH-1:0] fwd_rs2;
   logic             accept;
   logic             hold;

   // Handshake: a beat moves when valid && ready on that side. in_ready opens
   // whenever the register is empty or being drained this cycle, so accept and
   // transfer can overlap for one instruction per cycle. flush kills the
   // incoming beat and empties the register, taking priority over everything.
   always_comb begin
      in_ready = !valid_q || out_ready;
      accept   = in_valid && in_ready && !flush;
      hold     = valid_q && !out_ready;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q     <= 1'b0;
         alu_ctrl_q  <= ALU_ADD;
         rs1_data_q  <= '0;
         rs2_data_q  <= '0;
         imm_q       <= '0;
         pc_q        <= '0;
         rs1_q       <= '0;
         rs2_q       <= '0;
         rd_q        <= '0;
         src_a_q     <= SRC_A_RS1;
         src_b_q     <= SRC_B_RS2;
         reg_write_q <= 1'b0;
         is_branch_q <= 1'b0;
      end else begin
         if (flush) begin
            valid_q <= 1'b0;
         end else if (accept) begin
            valid_q <= 1'b1;
         end else if (out_ready) begin
            valid_q <= 1'b0;
         end

         if (accept) begin
            alu_ctrl_q  <= alu_ctrl_t'(id_alu_control);
            rs1_data_q  <= id_rs1_data;
            rs2_data_q  <= id_rs2_data;
            imm_q       <= id_imm;
            pc_q        <= id_pc;
            rs1_q       <= id_rs1;
            rs2_q       <= id_rs2;
            rd_q        <= id_rd;
            src_a_q     <= src_a_t'(id_src_a);
            src_b_q     <= src_b_t'(id_src_b);
            reg_write_q <= id_reg_write;
            is_branch_q <= id_is_branch;
         end else if (hold && !flush) begin
            // Latch forwarded operands while stalled so they outlive the producer.
            rs1_data_q <= fwd_rs1;
            rs2_data_q <= fwd_rs2;
         end
      end
   end

   fwd_mux #(.WIDTH(WIDTH), .IDX_W(RA_W)) u_fwd_rs1 (
      .rs            (rs1_q),
      .reg_data      (rs1_data_q),
      .mem_reg_write (mem_reg_write),
      .mem_rd        (mem_rd),
      .mem_result    (mem_result),
      .wb_reg_write  (wb_reg_write),
      .wb_rd         (wb_rd),
      .wb_result     (wb_result),
      .data          (fwd_rs1)
   );

   fwd_mux #(.WIDTH(WIDTH), .IDX_W(RA_W)) u_fwd_rs2 (
      .rs            (rs2_q),
      .reg_data      (rs2_data_q),
      .mem_reg_write (mem_reg_write),
      .mem_rd        (mem_rd),
      .mem_result    (mem_result),
      .wb_reg_write  (wb_reg_write),
      .wb_rd         (wb_rd),
      .wb_result     (wb_result),
      .data          (fwd_rs2)
   );

   always_comb begin
      ex_a = '0;
      case (src_a_q)
         SRC_A_RS1: ex_a = fwd_rs1;
         SRC_A_PC:  ex_a = pc_q;
         default:   ex_a = '0;
      endcase
   end

   always_comb begin
      ex_b           = (src_b_q == SRC_B_IMM) ? imm_q : fwd_rs2;
      ex_store_data  = fwd_rs2;
      ex_alu_control = alu_ctrl_q;
      ex_pc          = pc_q;
      ex_imm         = imm_q;
      ex_rd          = rd_q;
      out_valid      = valid_q;
      ex_reg_write   = reg_write_q && valid_q;
      ex_is_branch   = is_branch_q && valid_q;
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: handshake, forwarding priority, stall
// refresh, flush, operand sources and asynchronous reset.
module tb_id_ex_stage;

   localparam int WIDTH = 32;
   localparam int RA_W  = 5;

   logic             clk;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       id_alu_control;
   logic [WIDTH-1:0] id_rs1_data;
   logic [WIDTH-1:0] id_rs2_data;
   logic [WIDTH-1:0] id_imm;
   logic [WIDTH-1:0] id_pc;
   logic [RA_W-1:0]  id_rs1;
   logic [RA_W-1:0]  id_rs2;
   logic [RA_W-1:0]  id_rd;
   logic [1:0]       id_src_a;
   logic             id_src_b;
   logic             id_reg_write;
   logic             id_is_branch;
   logic             mem_reg_write;
   logic [RA_W-1:0]  mem_rd;
   logic [WIDTH-1:0] mem_result;
   logic             wb_reg_write;
   logic [RA_W-1:0]  wb_rd;
   logic [WIDTH-1:0] wb_result;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [3:0]       ex_alu_control;
   logic [WIDTH-1:0] ex_a;
   logic [WIDTH-1:0] ex_b;
   logic [WIDTH-1:0] ex_store_data;
   logic [WIDTH-1:0] ex_pc;
   logic [WIDTH-1:0] ex_imm;
   logic [RA_W-1:0]  ex_rd;
   logic             ex_reg_write;
   logic             ex_is_branch;

   int checks = 0;
   int errors = 0;

   id_ex_stage #(.WIDTH(WIDTH), .RA_W(RA_W)) dut (
      .clk            (clk),
      .reset          (reset),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .id_alu_control (id_alu_control),
      .id_rs1_data    (id_rs1_data),
      .id_rs2_data    (id_rs2_data),
      .id_imm         (id_imm),
      .id_pc          (id_pc),
      .id_rs1         (id_rs1),
      .id_rs2         (id_rs2),
      .id_rd          (id_rd),
      .id_src_a       (id_src_a),
      .id_src_b       (id_src_b),
      .id_reg_write   (id_reg_write),
      .id_is_branch   (id_is_branch),
      .mem_reg_write  (mem_reg_write),
      .mem_rd         (mem_rd),
      .mem_result     (mem_result),
      .wb_reg_write   (wb_reg_write),
      .wb_rd          (wb_rd),
      .wb_result      (wb_result),
      .flush          (flush),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .ex_alu_control (ex_alu_control),
      .ex_a           (ex_a),
      .ex_b           (ex_b),
      .ex_store_data  (ex_store_data),
      .ex_pc          (ex_pc),
      .ex_imm         (ex_imm),
      .ex_rd          (ex_rd),
      .ex_reg_write   (ex_reg_write),
      .ex_is_branch   (ex_is_branch)
   );

   // Clock and watchdog
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_id(input logic [3:0]  ctrl,
                           input logic [31:0] rs1d,
                           input logic [31:0] rs2d,
                           input logic [31:0] imm,
                           input logic [31:0] pc,
                           input logic [4:0]  rs1,
                           input logic [4:0]  rs2,
                           input logic [4:0]  rd,
                           input logic [1:0]  sa,
                           input logic        sb,
                           input logic        rw,
                           input logic        br);
      in_valid       = 1'b1;
      id_alu_control = ctrl;
      id_rs1_data    = rs1d;
      id_rs2_data    = rs2d;
      id_imm         = imm;
      id_pc          = pc;
      id_rs1         = rs1;
      id_rs2         = rs2;
      id_rd          = rd;
      id_src_a       = sa;
      id_src_b       = sb;
      id_reg_write   = rw;
      id_is_branch   = br;
   endtask

   task automatic clear_fwd();
      mem_reg_write = 1'b0;
      mem_rd        = '0;
      mem_result    = '0;
      wb_reg_write  = 1'b0;
      wb_rd         = '0;
      wb_result     = '0;
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      clear_fwd();
      drive_id(4'h0, '0, '0, '0, '0, '0, '0, '0, 2'b00, 1'b0, 1'b0, 1'b0);
      in_valid = 1'b0;

      // Reset state
      step();
      step();
      check("rst_out_valid", out_valid, 0);
      check("rst_ex_a", ex_a, 0);
      check("rst_ex_b", ex_b, 0);
      check("rst_store", ex_store_data, 0);
      check("rst_reg_write", ex_reg_write, 0);
      check("rst_is_branch", ex_is_branch, 0);
      check("rst_in_ready", in_ready, 1);
      reset = 1'b0;

      // 1. Basic pass-through
      drive_id(4'b0000, 32'd5, 32'd7, 32'h0, 32'h0, 5'd1, 5'd2, 5'd3, 2'b00, 1'b0, 1'b1, 1'b0);
      step();
      in_valid = 1'b0;
      check("t1_out_valid", out_valid, 1);
      check("t1_ex_a", ex_a, 5);
      check("t1_ex_b", ex_b, 7);
      check("t1_alu_ctrl", ex_alu_control, 4'b0000);
      check("t1_rd", ex_rd, 3);
      check("t1_reg_write", ex_reg_write, 1);
      step();
      check("t1_bubble_valid", out_valid, 0);
      check("t1_bubble_rw", ex_reg_write, 0);

      // 2. Forwarding priority on rs1 = x3
      drive_id(4'b0001, 32'h99, 32'h44, 32'h0, 32'h0, 5'd3, 5'd4, 5'd8, 2'b00, 1'b0, 1'b1, 1'b0);
      step();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      mem_reg_write = 1'b1; mem_rd = 5'd3; mem_result = 32'h11;
      wb_reg_write  = 1'b1; wb_rd  = 5'd3; wb_result  = 32'h22;
      #1;
      check("t2_mem_over_wb", ex_a, 32'h11);
      mem_reg_write = 1'b0;
      #1;
      check("t2_wb_only", ex_a, 32'h22);
      wb_reg_write = 1'b0;
      #1;
      check("t2_stored", ex_a, 32'h99);
      check("t2_alu_ctrl", ex_alu_control, 4'b0001);
      out_ready = 1'b1;
      clear_fwd();
      drive_id(4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd8, 2'b00, 1'b0, 1'b1, 1'b0);
      step();
      in_valid = 1'b0;
      mem_reg_write = 1'b1; mem_rd = 5'd0; mem_result = 32'h11;
      wb_reg_write  = 1'b1; wb_rd  = 5'd0; wb_result  = 32'h22;
      #1;
      check("t2_x0_a", ex_a, 0);
      check("t2_x0_store", ex_store_data, 0);
      clear_fwd();

      // 3. Stall refresh: WB forwards x7 = 0xAB for one cycle only
      drive_id(4'b0000, 32'h5, 32'h1, 32'h0, 32'h0, 5'd5, 5'd7, 5'd9, 2'b00, 1'b0, 1'b1, 1'b0);
      step();
      out_ready = 1'b0;
      drive_id(4'b0111, 32'h66, 32'h77, 32'h0, 32'h0, 5'd10, 5'd11, 5'd12, 2'b00, 1'b0, 1'b1, 1'b0);
      wb_reg_write = 1'b1; wb_rd = 5'd7; wb_result = 32'hAB;
      #1;
      check("t3_c1_ex_b", ex_b, 32'hAB);
      check("t3_c1_in_ready", in_ready, 0);
      step();
      clear_fwd();
      #1;
      check("t3_c2_ex_b", ex_b, 32'hAB);
      check("t3_c2_store", ex_store_data, 32'hAB);
      check("t3_c2_rd", ex_rd, 9);
      check("t3_c2_out_valid", out_valid, 1);
      step();
      check("t3_c3_ex_b", ex_b, 32'hAB);
      check("t3_c3_store", ex_store_data, 32'hAB);
      check("t3_c3_rd", ex_rd, 9);
      check("t3_c3_in_ready", in_ready, 0);
      out_ready = 1'b1;
      step();
      check("t3_next_rd", ex_rd, 12);
      check("t3_next_ex_b", ex_b, 32'h77);
      check("t3_next_ctrl", ex_alu_control, 4'b0111);
      check("t3_next_valid", out_valid, 1);

      // 4. Flush beats a simultaneous accept
      drive_id(4'b0000, 32'h1, 32'h2, 32'h0, 32'h0, 5'd1, 5'd2, 5'd4, 2'b00, 1'b0, 1'b1, 1'b0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("t4_flush_valid", out_valid, 0);
      check("t4_flush_rw", ex_reg_write, 0);
      check("t4_flush_in_ready", in_ready, 1);
      drive_id(4'b1100, 32'h1, 32'h2, 32'h0, 32'h0, 5'd1, 5'd2, 5'd5, 2'b00, 1'b0, 1'b1, 1'b1);
      step();
      in_valid = 1'b0;
      check("t4_clean_valid", out_valid, 1);
      check("t4_clean_rd", ex_rd, 5);
      check("t4_clean_branch", ex_is_branch, 1);
      check("t4_clean_ctrl", ex_alu_control, 4'b1100);

      // 5. PC / immediate sources with rs2 forwarded from MEM
      drive_id(4'b0000, 32'h9, 32'h33, 32'hFFFF_FFFC, 32'h100, 5'd1, 5'd6, 5'd2, 2'b01, 1'b1, 1'b0, 1'b0);
      step();
      in_valid = 1'b0;
      mem_reg_write = 1'b1; mem_rd = 5'd6; mem_result = 32'h55;
      #1;
      check("t5_ex_a_pc", ex_a, 32'h100);
      check("t5_ex_b_imm", ex_b, 32'hFFFF_FFFC);
      check("t5_store_fwd", ex_store_data, 32'h55);
      check("t5_ex_pc", ex_pc, 32'h100);
      check("t5_ex_imm", ex_imm, 32'hFFFF_FFFC);
      clear_fwd();
      drive_id(4'b0000, 32'h123, 32'h0, 32'h0, 32'h200, 5'd1, 5'd2, 5'd2, 2'b10, 1'b0, 1'b0, 1'b0);
      step();
      check("t5_src_zero", ex_a, 0);
      drive_id(4'b0000, 32'h456, 32'h0, 32'h0, 32'h300, 5'd1, 5'd2, 5'd2, 2'b11, 1'b0, 1'b0, 1'b0);
      step();
      in_valid = 1'b0;
      check("t5_src_rsvd", ex_a, 0);

      // 6. Asynchronous reset between edges
      drive_id(4'b0010, 32'hDEAD, 32'hBEEF, 32'h0, 32'h0, 5'd1, 5'd2, 5'd3, 2'b00, 1'b0, 1'b1, 1'b0);
      step();
      in_valid = 1'b0;
      check("t6_pre_rw", ex_reg_write, 1);
      check("t6_pre_ex_a", ex_a, 32'hDEAD);
      #2;
      reset = 1'b1;
      #1;
      check("t6_rst_valid", out_valid, 0);
      check("t6_rst_rw", ex_reg_write, 0);
      check("t6_rst_ex_a", ex_a, 0);
      check("t6_rst_ex_b", ex_b, 0);
      check("t6_rst_in_ready", in_ready, 1);
      step();
      reset = 1'b0;
      step();
      check("t6_post_valid", out_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Registered ID/EX pipeline stage that sits directly upstream of the execute ALU.
- Captures decoded instruction fields from ID.
- Resolves EX-side operand forwarding from the MEM and WB stages.
- Applies the operand-source muxes and drives the ALU's 4-bit control and a/b operands, plus the branch, store-data and writeback fields that travel with the instruction.
- Uses a valid/ready handshake on both sides, with flush for branch squash.

Parameters:
WIDTH, 32, datapath width; matches the ALU WIDTH.
RA_W, 5, register-address width.

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  ID presents an instruction
in_ready  out  1  stage can accept this cycle
id_alu_control  in  4  ALU operation code
id_rs1_data  in  WIDTH  register-file read port 1
id_rs2_data  in  WIDTH  register-file read port 2
id_imm  in  WIDTH  sign-extended immediate
id_pc  in  WIDTH  instruction PC
id_rs1  in  RA_W  source register 1 index
id_rs2  in  RA_W  source register 2 index
id_rd  in  RA_W  destination register index
id_src_a  in  2  00 = rs1, 01 = pc, 10 = zero, 11 = reserved (treat as zero)
id_src_b  in  1  0 = rs2, 1 = imm
id_reg_write  in  1  instruction writes rd
id_is_branch  in  1  conditional branch
mem_reg_write  in  1  MEM-stage instruction writes a register
mem_rd  in  RA_W  MEM-stage destination index
mem_result  in  WIDTH  MEM-stage result
wb_reg_write  in  1  WB-stage instruction writes a register
wb_rd  in  RA_W  WB-stage destination index
wb_result  in  WIDTH  WB-stage result
flush  in  1  squash stage contents
out_valid  out  1  EX holds a valid instruction
out_ready  in  1  downstream can take the instruction
ex_alu_control  out  4  to ALU control
ex_a  out  WIDTH  to ALU operand a
ex_b  out  WIDTH  to ALU operand b
ex_store_data  out  WIDTH  forwarded rs2 value (store data)
ex_pc  out  WIDTH  PC, for branch-target computation
ex_imm  out  WIDTH  immediate
ex_rd  out  RA_W  destination register index
ex_reg_write  out  1  gated with out_valid
ex_is_branch  out  1  gated with out_valid

Behaviour:
- Reset (asynchronous, immediate, also mid-operation):
  - out_valid = 0.
  - All stored fields = 0.
  - Hence ex_a = ex_b = ex_store_data = 0, ex_reg_write = 0, ex_is_branch = 0, in_ready = 1.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept when in_valid && in_ready && !flush: all id_* fields are captured next edge and out_valid <= 1.
  - Transfer when out_valid && out_ready without a new accept: out_valid <= 0.
  - Accept and transfer in the same cycle give full throughput, one instruction per cycle.
- Latency: one cycle from accept to out_valid.
- Flush:
  - Next edge out_valid <= 0 and nothing is captured.
  - Flush wins over a simultaneous accept and over a hold.
- Forwarding (combinational, per operand, on the stored rs index):
  - MEM hit = mem_reg_write && mem_rd == rs && rs != 0.
  - WB hit = wb_reg_write && wb_rd == rs && rs != 0.
  - Priority is MEM, then WB, then stored data.
  - x0 is never forwarded.
- Hold/refresh:
  - While out_valid && !out_ready, stored rs1/rs2 data are overwritten each edge with the forwarded values.
  - A forwarded value therefore survives after the producer retires.
  - Control fields and indices are held unchanged.
- Operand muxing (after forwarding):
  - ex_a = fwd_rs1, ex_pc, or 0 per src_a.
  - ex_b = fwd_rs2 or ex_imm per src_b.
  - ex_store_data = fwd_rs2 regardless of src_b.
- Bubbles: when out_valid = 0, ex_reg_write and ex_is_branch are 0. Other outputs are don't-care but must not be X after reset.
- No arithmetic in this block; all widths pass through unchanged.

Decomposition:
- Shared package rv32i_pkg holds:
  - alu_ctrl_t: a 4-bit enum with ADD = 0000, SUB = 0001, AND = 0010, OR = 0011, SLL = 0100, SLT = 0101, SLTU = 0110, XOR = 0111, SRA = 1000, SRL = 1001, BGE = 1010, BGEU = 1011, BNE = 1100.
  - src_a_t and src_b_t enums.
  - The RA_W constant.
- One sub-module, fwd_mux: index compare plus priority select, instantiated twice (rs1, rs2).

Test Plan:
1. Basic pass-through: assert reset, release, then accept control = 0000, rs1_data = 5, rs2_data = 7, src_a = 00, src_b = 0 -> next cycle out_valid = 1, ex_a = 5, ex_b = 7, ex_alu_control = 0000.
2. Forwarding priority: stored rs1 = 3; mem_rd = 3, mem_result = 0x11; wb_rd = 3, wb_result = 0x22; both write enables set -> ex_a = 0x11. Drop mem_reg_write -> ex_a = 0x22. Set rs1 = 0 with mem_rd = 0 -> ex_a = stored data (0 for x0).
3. Stall refresh: out_ready = 0 for 3 cycles; WB forward of x7 = 0xAB on rs2 during cycle 1 only -> ex_b and ex_store_data remain 0xAB in cycles 2-3; in_ready = 0; concurrent in_valid is not captured.
4. Flush vs accept: in_valid = 1 and flush = 1 with out_ready = 1 -> next cycle out_valid = 0 and ex_reg_write = 0; the following clean accept proceeds normally.
5. Immediate/PC sources: src_a = 01, pc = 0x100, src_b = 1, imm = 0xFFFFFFFC, rs2 forwarded from MEM = 0x55 -> ex_a = 0x100, ex_b = 0xFFFFFFFC, ex_store_data = 0x55.
6. Async reset mid-stream: reset asserted between edges while out_valid = 1 and ex_reg_write = 1 -> out_valid, ex_reg_write, ex_a and ex_b drop to 0 before the next edge; in_ready = 1.
